store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//  Receiver of commit_store1_valid/commit_store2_valid from the commit stage. Holds executed
//  stores in program order and marks the oldest ones committed when commit fires. Drains committed
//  stores to the dcache over the req/addr_ok/data_ok write interface and forwards data to loads.
//  Sits between the mem execute pipe, commit_stage and the dcache port.
// PARAMETERS
//  SB_DEPTH  8   entries (power of two); pointers are $clog2(SB_DEPTH)+1 bits incl. wrap bit
//  ADDR_W    32  physical byte address width
//  DATA_W    32  store data width; wstrb is DATA_W/8
// PORTS
//  clk               in   1        clock
//  resetn            in   1        asynchronous, active-low reset
//  flush             in   1        pipeline flush from commit_stage
//  enq_valid         in   1        executed store from mem pipe (program order, no exception)
//  enq_addr          in   ADDR_W   store byte address (word aligned by wstrb)
//  enq_data          in   DATA_W   store data, already lane-shifted
//  enq_wstrb         in   4        byte enables
//  sb_allowin        out  1        entry free; enq accepted only when 1
//  commit_store1_valid in 1        commit oldest uncommitted store
//  commit_store2_valid in 1        commit next store (only with store1)
//  ld_addr           in   ADDR_W   load lookup address
//  ld_wstrb          in   4        bytes the load needs
//  fwd_hit           out  1        youngest matching entry covers all ld_wstrb bytes
//  fwd_data          out  DATA_W   data of that entry
//  fwd_conflict      out  1        word match but partial cover: load must replay
//  data_req          out  1        dcache write request
//  data_wr           out  1        tied 1 when data_req
//  data_addr         out  ADDR_W   head entry address
//  data_wdata        out  DATA_W   head entry data
//  data_wstrb        out  4        head entry wstrb
//  data_addr_ok      in   1        dcache accepted request
//  data_data_ok      in   1        dcache completed write
//  sb_empty          out  1        no valid entries and drain FSM IDLE
// BEHAVIOUR
//  - Reset (resetn=0, async): head=cmt=tail=0, FSM=IDLE; data_req=0, fwd_hit=0, fwd_conflict=0,
//    sb_allowin=1, sb_empty=1, data_* buses 0. In-flight dcache op is abandoned (global reset).
//  - Pointers: head<=cmt<=tail (mod wrap). count=tail-head, ncmt=cmt-head, full: count==SB_DEPTH.
//  - sb_allowin = !full (registered count; same-cycle pop not credited). Enq writes entry[tail],
//    tail+=1; entry is visible to forwarding from the next cycle.
//  - Commit: cmt += store1+store2. store2 without store1, or commits exceeding tail-cmt, are
//    illegal (assertion); RTL does not guard them.
//  - Flush: tail <= cmt_next (cmt after this cycle's commits); enq in the flush cycle is dropped.
//    Committed entries are kept and keep draining; drain FSM is not disturbed.
//  - Drain FSM: IDLE -> REQ when ncmt>0 (data_req=1, head entry on data_*, held stable);
//    REQ -> WAIT on data_addr_ok; WAIT -> IDLE on data_data_ok, head+=1 same edge.
//    data_data_ok never arrives in the addr_ok cycle. One bubble cycle between requests.
//  - Forwarding (comb): scan all valid entries (committed or not) for addr[ADDR_W-1:2] match;
//    choose youngest (closest to tail). If (wstrb & ld_wstrb)==ld_wstrb -> fwd_hit; else if any
//    overlap -> fwd_conflict. Entry in REQ/WAIT still counts until popped.
//  - Wrap-around: index = ptr[$clog2(SB_DEPTH)-1:0]; full/empty by wrap-bit compare.
//  - Simultaneous enq+pop when full: enq refused (allowin=0); commit+flush+pop all in one cycle
//    apply independently per the rules above.
//  - sb_empty = (count==0) && FSM==IDLE; used by commit for sync/eret/cache ops.
// STRUCTURE
//  - Package (cpu.svh): sb_entry_t {addr, data, wstrb}, sb_state_t {SB_IDLE,SB_REQ,SB_WAIT},
//    SB_DEPTH localparam.
//  - Sub-module store_buffer_fwd: age-ordered CAM lookup (entries, head, tail -> hit/conflict/data).
// TESTING
//  1. Reset then enq A=0x100 D=0x11223344 wstrb=F, commit1 next cycle -> data_req=1 addr 0x100;
//     addr_ok, then data_ok -> head advances, sb_empty=1 one cycle later.
//  2. Fill 8 stores, no commit -> sb_allowin=0, 9th enq ignored; commit2 twice -> 4 drains in order.
//  3. 3 uncommitted + 2 committed stores, flush -> tail=cmt, only 2 writes reach dcache.
//  4. Stores 0x200 wstrb=F D=0xAAAAAAAA then 0x200 wstrb=1 D=0x55; load 0x200 wstrb=1 -> hit 0x55;
//     load wstrb=F -> fwd_conflict=1, fwd_hit=0.
//  5. Wrap: 20 enq/commit/drain cycles -> addresses drain in enq order across pointer wrap.
//  6. resetn low while FSM in WAIT -> data_req=0, all pointers 0, sb_allowin=1 immediately.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the store buffer: entry layout, drain FSM states, pointer widths.
// Pointers carry one extra wrap bit above the entry index so full and empty can be told apart.
package store_buffer_pkg;

  localparam int SB_DEPTH = 8;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;
  localparam int IDX_W    = $clog2(SB_DEPTH);
  localparam int PTR_W    = IDX_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] wstrb;
  } sb_entry_t;

  localparam int ENTRY_W = $bits(sb_entry_t);

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_REQ,
    SB_WAIT
  } sb_state_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// Age-ordered word-address CAM over the live window [head, tail) of the store buffer.
// Youngest matching entry decides: full byte cover forwards data, partial overlap flags a replay.
module store_buffer_fwd
  import store_buffer_pkg::*;
(
  input  logic [SB_DEPTH-1:0][ENTRY_W-1:0] i_entries,
  input  logic [PTR_W-1:0]                 i_head,
  input  logic [PTR_W-1:0]                 i_tail,
  input  logic [ADDR_W-1:0]                i_ld_addr,
  input  logic [STRB_W-1:0]                i_ld_wstrb,
  output logic                             o_fwd_hit,
  output logic [DATA_W-1:0]                o_fwd_data,
  output logic                             o_fwd_conflict
);

  logic [PTR_W-1:0]  w_count;
  logic [PTR_W-1:0]  w_ptr;
  logic              w_found;
  sb_entry_t         w_e;
  sb_entry_t         w_sel;
  logic [STRB_W-1:0] w_ovl;
  logic              w_unused_ld;

  assign w_count     = i_tail - i_head;
  assign w_unused_ld = ^i_ld_addr[1:0];

  always_comb begin
    w_found        = 1'b0;
    w_sel          = '0;
    w_ptr          = '0;
    w_e            = '0;
    w_ovl          = '0;
    o_fwd_hit      = 1'b0;
    o_fwd_conflict = 1'b0;
    o_fwd_data     = '0;
    // Walk oldest to youngest so the last match seen is the youngest one.
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_ptr = i_head + PTR_W'(i);
      w_e   = i_entries[w_ptr[IDX_W-1:0]];
      if ((PTR_W'(i) < w_count) && (w_e.addr[ADDR_W-1:2] == i_ld_addr[ADDR_W-1:2])) begin
        w_found = 1'b1;
        w_sel   = w_e;
      end
    end
    w_ovl          = w_sel.wstrb & i_ld_wstrb;
    o_fwd_hit      = w_found && (w_ovl == i_ld_wstrb);
    o_fwd_conflict = w_found && !o_fwd_hit && (|w_ovl);
    o_fwd_data     = o_fwd_hit ? w_sel.data : '0;
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: holds executed stores, marks the oldest committed, drains them to the
// dcache one at a time over req/addr_ok/data_ok, and forwards store data to younger loads.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_flush,
  input  logic              i_enq_valid,
  input  logic [ADDR_W-1:0] i_enq_addr,
  input  logic [DATA_W-1:0] i_enq_data,
  input  logic [STRB_W-1:0] i_enq_wstrb,
  output logic              o_sb_allowin,
  input  logic              i_commit_store1_valid,
  input  logic              i_commit_store2_valid,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [STRB_W-1:0] i_ld_wstrb,
  output logic              o_fwd_hit,
  output logic [DATA_W-1:0] o_fwd_data,
  output logic              o_fwd_conflict,
  output logic              o_data_req,
  output logic              o_data_wr,
  output logic [ADDR_W-1:0] o_data_addr,
  output logic [DATA_W-1:0] o_data_wdata,
  output logic [STRB_W-1:0] o_data_wstrb,
  input  logic              i_data_addr_ok,
  input  logic              i_data_data_ok,
  output logic              o_sb_empty
);

  sb_entry_t [SB_DEPTH-1:0] r_entries;
  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_cmt;
  logic [PTR_W-1:0]         r_tail;
  sb_state_t                r_state;
  sb_state_t                w_state_nxt;

  logic [PTR_W-1:0] w_count;
  logic [PTR_W-1:0] w_ncmt;
  logic [PTR_W-1:0] w_cmt_inc;
  logic [PTR_W-1:0] w_cmt_nxt;
  logic             w_full;
  logic             w_enq_fire;
  logic             w_pop;
  sb_entry_t        w_head_e;

  assign w_count    = r_tail - r_head;
  assign w_ncmt     = r_cmt - r_head;
  assign w_full     = (r_tail[IDX_W] != r_head[IDX_W]) && (r_tail[IDX_W-1:0] == r_head[IDX_W-1:0]);
  assign w_enq_fire = i_enq_valid && !w_full && !i_flush;
  assign w_cmt_inc  = PTR_W'(i_commit_store1_valid) + PTR_W'(i_commit_store2_valid);
  assign w_cmt_nxt  = r_cmt + w_cmt_inc;
  assign w_pop      = (r_state == SB_WAIT) && i_data_data_ok;
  assign w_head_e   = r_entries[r_head[IDX_W-1:0]];

  assign o_sb_allowin = !w_full;
  assign o_sb_empty   = (w_count == '0) && (r_state == SB_IDLE);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_head  <= '0;
      r_cmt   <= '0;
      r_tail  <= '0;
      r_state <= SB_IDLE;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_cmt   <= w_cmt_nxt;
      // Flush drops only uncommitted stores; committed ones keep draining.
      r_tail  <= i_flush ? w_cmt_nxt : (r_tail + PTR_W'(w_enq_fire));
      r_state <= w_state_nxt;
    end
  end

  // Payload storage needs no reset: only entries inside [head, tail) are ever observed.
  always_ff @(posedge i_clk) begin
    if (w_enq_fire) begin
      r_entries[r_tail[IDX_W-1:0]] <= '{addr: i_enq_addr, data: i_enq_data, wstrb: i_enq_wstrb};
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_data_req   = 1'b0;
    o_data_wr    = 1'b0;
    o_data_addr  = '0;
    o_data_wdata = '0;
    o_data_wstrb = '0;
    case (r_state)
      SB_IDLE: if (w_ncmt != '0) w_state_nxt = SB_REQ;
      SB_REQ:  if (i_data_addr_ok) w_state_nxt = SB_WAIT;
      SB_WAIT: if (i_data_data_ok) w_state_nxt = SB_IDLE;
      default: w_state_nxt = SB_IDLE;
    endcase
    if (r_state == SB_REQ) begin
      o_data_req = 1'b1;
      o_data_wr  = 1'b1;
    end
    if (r_state != SB_IDLE) begin
      o_data_addr  = w_head_e.addr;
      o_data_wdata = w_head_e.data;
      o_data_wstrb = w_head_e.wstrb;
    end
  end

  store_buffer_fwd u_fwd (
    .i_entries      (r_entries),
    .i_head         (r_head),
    .i_tail         (r_tail),
    .i_ld_addr      (i_ld_addr),
    .i_ld_wstrb     (i_ld_wstrb),
    .o_fwd_hit      (o_fwd_hit),
    .o_fwd_data     (o_fwd_data),
    .o_fwd_conflict (o_fwd_conflict)
  );

  a_store2_needs_store1: assert property (@(posedge i_clk) disable iff (!i_resetn)
    !(i_commit_store2_valid && !i_commit_store1_valid));
  a_commit_in_window: assert property (@(posedge i_clk) disable iff (!i_resetn)
    w_cmt_inc <= PTR_W'(r_tail - r_cmt));

endmodule
